// File: rtl/lz_normalizer_pkg.sv
// Shared types and defaults for the leading-zero normalizer.
package lz_normalizer_pkg;

  // Default operand width.
  localparam int LZN_WIDTH = 32;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lz_normalizer_if.sv
// Operand/result handshake bundle for the leading-zero normalizer.
interface lz_normalizer_if
  import lz_normalizer_pkg::*;
#(
  parameter int WIDTH = LZN_WIDTH
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_shift;
  logic             out_zero;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_zero
  );

  // Normalizer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_zero
  );
endinterface

// File: rtl/lz_normalizer_norm_step.sv
// One binary-search step: shift left by i_amt when the top i_amt bits are zero.
module norm_step #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [CW-1:0]    i_amt,
  output logic [WIDTH-1:0] o_data,
  output logic             o_took
);
  logic [WIDTH-1:0] w_mask;

  // Mask covering the top i_amt bits of the operand.
  assign w_mask = ~({WIDTH{1'b1}} >> i_amt);
  assign o_took = ((i_data & w_mask) == '0);
  assign o_data = o_took ? (i_data << i_amt) : i_data;
endmodule

// File: rtl/lz_normalizer.sv
// Iterative leading-zero normalizer: log2(WIDTH) binary-search shift steps
// over a single working register, one step per cycle.
module lz_normalizer
  import lz_normalizer_pkg::*;
#(
  parameter int WIDTH = LZN_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  lz_normalizer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int LG = $clog2(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_step;

  logic [CW-1:0]    w_amt;
  logic [WIDTH-1:0] w_sh;
  logic             w_took;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;

  // Step size 2^k selected by the step index; largest step first.
  assign w_amt     = CW'(1) << r_step;
  assign w_last    = (r_step == '0);
  assign w_cnt_nxt = r_cnt + (w_took ? w_amt : '0);

  norm_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
    .i_data (r_work),
    .i_amt  (w_amt),
    .o_data (w_sh),
    .o_took (w_took)
  );

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_step  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.in_data;
            r_cnt   <= '0;
            r_step  <= CW'(LG - 1);
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work <= w_sh;
          if (w_last) begin
            // Shifting never drops a one, so an all-zero result means a zero
            // operand; report the full width instead of the WIDTH-1 sum.
            r_cnt   <= (w_sh == '0) ? CW'(WIDTH) : w_cnt_nxt;
            r_state <= ST_DONE;
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_step <= r_step - CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_work;
  assign bus.out_shift = r_cnt;
  // Count reaches WIDTH only through the zero fix-up.
  assign bus.out_zero  = (r_cnt == CW'(WIDTH));
endmodule
